safe_code_lock: RTL



---
 rtl/safe_pkg.sv | 18 +
 rtl/safe_cycle_timer.sv | 28 ++
 rtl/safe_code_lock.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/safe_pkg.sv
// Key codes shared with the keypad scanner and the lock state encoding.
package safe_pkg;

    localparam int unsigned KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'd9;
    localparam logic [KEY_W-1:0] KEY_HASH      = 4'd10;
    localparam logic [KEY_W-1:0] KEY_STAR      = 4'd11;
    localparam logic [KEY_W-1:0] KEY_NONE      = 4'd13;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_SET     = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

endpackage

// File: rtl/safe_cycle_timer.sv
// Loadable saturating down-counter; done_c flags the last cycle of a loaded interval.
module safe_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement holds at zero instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done_c = (cnt_q == W'(1));

endmodule

// File: rtl/safe_code_lock.sv
// PIN-entry lock: digit buffer, combination compare, timed unlock, reprogramming and lockout.
module safe_code_lock
    import safe_pkg::*;
#(
    parameter int unsigned              PIN_LEN        = 4,
    parameter logic [4*PIN_LEN-1:0]     DEFAULT_PIN    = 16'h1234,
    parameter int unsigned              MAX_TRIES      = 3,
    parameter int unsigned              UNLOCK_CYCLES  = 50_000_000,
    parameter int unsigned              LOCKOUT_CYCLES = 500_000_000,
    parameter int unsigned              TIMEOUT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_code,
    output logic       unlock,
    output logic       locked_out,
    output logic       set_mode,
    output logic [3:0] digit_count,
    output logic       ok_pulse,
    output logic       err_pulse
);

    localparam int unsigned BUF_W   = 4 * PIN_LEN;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int unsigned MAX_CYC =
        (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
            ((UNLOCK_CYCLES > TIMEOUT_CYCLES) ? UNLOCK_CYCLES : TIMEOUT_CYCLES) :
            ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
    localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [BUF_W-1:0]    pin_q, pin_d;
    logic                ok_d, err_d;
    logic                take_digit;
    logic                tmr_load, tmr_en, tmr_done_c;
    logic [TMR_W-1:0]    tmr_val;
    logic                is_digit, is_hash, is_star;

    assign is_digit = (key_code <= KEY_DIGIT_MAX);
    assign is_hash  = (key_code == KEY_HASH);
    assign is_star  = (key_code == KEY_STAR);

    // One timer serves unlock, lockout and idle timeout; only one runs per state.
    assign tmr_en = (state_q != ST_ENTRY) || (cnt_q != '0);

    safe_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .done_c   (tmr_done_c)
    );

    // Next-state and datapath; a key always takes precedence over timer expiry.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        pin_d      = pin_q;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        take_digit = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;

        unique case (state_q)
            ST_ENTRY: begin
                if (is_digit) begin
                    take_digit = 1'b1;
                end else if (is_hash) begin
                    if ((cnt_q == CNT_W'(PIN_LEN)) && (buf_q == pin_q)) begin
                        ok_d     = 1'b1;
                        fail_d   = '0;
                        state_d  = ST_OPEN;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(UNLOCK_CYCLES);
                    end else begin
                        err_d  = 1'b1;
                        fail_d = fail_q + FAIL_W'(1);
                        if (fail_d == FAIL_W'(MAX_TRIES)) begin
                            state_d  = ST_LOCKOUT;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(LOCKOUT_CYCLES);
                        end
                    end
                    buf_d = '0;
                    cnt_d = '0;
                end else if (is_star) begin
                    buf_d = '0;
                    cnt_d = '0;
                end else if ((cnt_q != '0) && tmr_done_c) begin
                    buf_d = '0;
                    cnt_d = '0;
                end
            end
            ST_OPEN: begin
                if (is_hash) begin
                    state_d = ST_ENTRY;
                end else if (is_star) begin
                    state_d  = ST_SET;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TIMEOUT_CYCLES);
                end else if (tmr_done_c) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_SET: begin
                if (is_digit) begin
                    take_digit = 1'b1;
                end else if (is_hash) begin
                    if (cnt_q == CNT_W'(PIN_LEN)) begin
                        pin_d = buf_q;
                        ok_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_ENTRY;
                end else if (is_star || tmr_done_c) begin
                    state_d = ST_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_done_c) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_ENTRY;
        endcase

        // Digit entry is shared by ENTRY and SET; every accepted digit restarts the idle window.
        if (take_digit) begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT_CYCLES);
            if (cnt_q < CNT_W'(PIN_LEN)) begin
                buf_d = (buf_q << 4) | BUF_W'(key_code);
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                err_d = 1'b1;
            end
        end

        if (state_d != state_q) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ENTRY;
            buf_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            pin_q      <= DEFAULT_PIN;
            unlock     <= 1'b0;
            locked_out <= 1'b0;
            set_mode   <= 1'b0;
            ok_pulse   <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            pin_q      <= pin_d;
            unlock     <= (state_d == ST_OPEN);
            locked_out <= (state_d == ST_LOCKOUT);
            set_mode   <= (state_d == ST_SET);
            ok_pulse   <= ok_d;
            err_pulse  <= err_d;
        end
    end

    assign digit_count = cnt_q;

endmodule
